// File: rtl/onchip_mem_byte_loader_if.sv
// Byte-loader bus: control, 8-bit valid/ready stream in, and 32-bit RAM write port out.
interface onchip_mem_byte_loader_if #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 15
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_limit;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [CNT_W-1:0]  words_written;

    modport slave (
        input  start, base_addr, word_limit, in_data, in_valid, in_last,
        output in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
               mem_writedata, mem_clken, busy, done, overflow, words_written
    );

    modport master (
        output start, base_addr, word_limit, in_data, in_valid, in_last,
        input  in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
               mem_writedata, mem_clken, busy, done, overflow, words_written
    );
endinterface

// File: rtl/onchip_mem_byte_loader.sv
// Packs a byte stream little-endian into 32-bit words and writes them to
// consecutive on-chip RAM addresses from a programmed base, wrapping at MEM_DEPTH.
module onchip_mem_byte_loader #(
    parameter int ADDR_W    = 14,
    parameter int MEM_DEPTH = 10240,
    parameter int CNT_W     = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    onchip_mem_byte_loader_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(MEM_DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  limit_q, limit_d;
    logic [1:0]        lane_q, lane_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       data_q, data_d;
    logic [CNT_W-1:0]  ww_q, ww_d;
    logic              ovf_q, ovf_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [31:0]       mdata_q, mdata_d;
    logic              clken_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        limit_d = limit_q;
        lane_d  = lane_q;
        be_d    = be_q;
        data_d  = data_q;
        ww_d    = ww_q;
        ovf_d   = ovf_q;
        last_d  = last_q;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ptr_d   = ({1'b0, bus.base_addr} >= DEPTH_X) ? '0 : bus.base_addr;
                    limit_d = (bus.word_limit == '0) ? DEPTH_C : bus.word_limit;
                    lane_d  = '0;
                    be_d    = '0;
                    data_d  = '0;
                    ww_d    = '0;
                    ovf_d   = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.in_valid) begin
                    data_d[8*lane_q +: 8] = bus.in_data;
                    be_d[lane_q]          = 1'b1;
                    last_d                = bus.in_last;
                    if (lane_q == 2'd3 || bus.in_last) begin
                        // Output registers are loaded here so the RAM bus only moves at WRITE entry.
                        maddr_d = ptr_q;
                        mdata_d = data_d;
                        state_d = S_WRITE;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                ww_d   = ww_q + 1'b1;
                lane_d = '0;
                be_d   = '0;
                data_d = '0;
                ptr_d  = (ptr_q == LAST_A) ? '0 : ptr_q + 1'b1;
                if (last_q) begin
                    state_d = S_DONE;
                end else if (ww_q + 1'b1 == limit_q) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            limit_q <= '0;
            lane_q  <= '0;
            be_q    <= '0;
            data_q  <= '0;
            ww_q    <= '0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
            maddr_q <= '0;
            mdata_q <= '0;
            clken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            limit_q <= limit_d;
            lane_q  <= lane_d;
            be_q    <= be_d;
            data_q  <= data_d;
            ww_q    <= ww_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            clken_q <= 1'b1;
        end
    end

    assign bus.in_ready       = (state_q == S_FILL);
    assign bus.mem_chipselect = (state_q == S_WRITE);
    assign bus.mem_write      = (state_q == S_WRITE);
    assign bus.mem_byteenable = (state_q == S_WRITE) ? be_q : 4'b0000;
    assign bus.mem_address    = maddr_q;
    assign bus.mem_writedata  = mdata_q;
    assign bus.mem_clken      = clken_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = (state_q == S_DONE);
    assign bus.overflow       = ovf_q;
    assign bus.words_written  = ww_q;
endmodule

// File: tb/tb_onchip_mem_byte_loader.sv
// Directed bench for onchip_mem_byte_loader: a packing model predicts every RAM write
// and the completion status; a negedge monitor compares the DUT against it each cycle.
module tb_onchip_mem_byte_loader;
    localparam int ADDR_W    = 14;
    localparam int MEM_DEPTH = 10240;
    localparam int CNT_W     = 15;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [3:0]        be;
        logic [31:0]       d;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    onchip_mem_byte_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

    onchip_mem_byte_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    wr_t  exp_q[$];
    wr_t  wlog[$];
    int   exp_ww;
    int   exp_ovf;
    int   exp_acc;
    logic [7:0] tx [0:15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    // Model: what the load must produce, from the byte list and load parameters alone.
    task automatic model_load(input int base, input int lim, input int n, input bit last_end);
        int p, L, lane;
        wr_t w;
        bit lst;
        p = (base >= MEM_DEPTH) ? 0 : base;
        L = (lim == 0) ? MEM_DEPTH : lim;
        exp_ww = 0; exp_ovf = 0; exp_acc = 0; lane = 0;
        w = '0;
        for (int i = 0; i < n; i++) begin
            w.d[8*lane +: 8] = tx[i];
            w.be[lane] = 1'b1;
            exp_acc++;
            lst = last_end && (i == n - 1);
            if (lane == 3 || lst) begin
                w.a = ADDR_W'(p);
                exp_q.push_back(w);
                exp_ww++;
                p = (p + 1) % MEM_DEPTH;
                lane = 0;
                w = '0;
                if (lst) break;
                if (exp_ww == L) begin exp_ovf = 1; break; end
            end else begin
                lane++;
            end
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!reset_n) begin
            chk("write_in_reset", {31'd0, bus.mem_write}, 32'd0);
        end else begin
            chk("clken", {31'd0, bus.mem_clken}, 32'd1);
            chk("cs_eq_write", {31'd0, bus.mem_chipselect}, {31'd0, bus.mem_write});
            if (bus.mem_write) begin
                wlog.push_back({bus.mem_address, bus.mem_byteenable, bus.mem_writedata});
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {18'd0, bus.mem_address}, {18'd0, e.a});
                    chk("wr_be", {28'd0, bus.mem_byteenable}, {28'd0, e.be});
                    chk("wr_data", bus.mem_writedata, e.d);
                end
            end else begin
                chk("be_idle", {28'd0, bus.mem_byteenable}, 32'd0);
            end
            if (bus.done) begin
                chk("words_written", {17'd0, bus.words_written}, 32'(exp_ww));
                chk("overflow", {31'd0, bus.overflow}, 32'(exp_ovf));
                chk("busy_in_done", {31'd0, bus.busy}, 32'd1);
            end
        end
    end

    task automatic run_load(input int base, input int lim, input int n, input bit last_end,
                            input bit bubble, input int mid, input bit start_in_done);
        int idx, cyc;
        bit v, tog, acc, got_done;
        model_load(base, lim, n, last_end);
        @(negedge clk);
        bus.start = 1'b1;
        bus.base_addr = ADDR_W'(base);
        bus.word_limit = CNT_W'(lim);
        @(negedge clk);
        bus.start = 1'b0;
        bus.base_addr = 14'h0155;
        bus.word_limit = 15'd3;
        idx = 0; cyc = 0; tog = 1'b1; got_done = 1'b0;
        while (!got_done && cyc < 300) begin
            v = (idx < n) && (!bubble || tog);
            tog = !tog;
            bus.in_valid = v;
            bus.in_data  = tx[idx];
            bus.in_last  = last_end && (idx == n - 1);
            bus.start    = (idx == mid);
            acc = v && bus.in_ready;
            @(negedge clk);
            cyc++;
            if (acc) idx++;
            if (bus.done) got_done = 1'b1;
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.start = start_in_done;
        chk("done_seen", {31'd0, got_done}, 32'd1);
        chk("bytes_accepted", 32'(idx), 32'(exp_acc));
        @(negedge clk);
        bus.start = 1'b0;
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("done_single", {31'd0, bus.done}, 32'd0);
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_bytes(input logic [63:0] v);
        for (int i = 0; i < 8; i++) tx[i] = v[8*i +: 8];
    endtask

    initial begin
        int base_log;
        bus.start = 1'b0; bus.base_addr = '0; bus.word_limit = '0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        for (int i = 0; i < 16; i++) tx[i] = 8'h00;
        #8;
        chk("rst_outputs", {bus.in_ready, bus.mem_chipselect, bus.mem_write, bus.busy,
                            bus.done, bus.overflow, bus.mem_clken, bus.mem_byteenable}, 32'd0);
        chk("rst_ww", {17'd0, bus.words_written}, 32'd0);
        chk("rst_addr_data", {18'd0, bus.mem_address} | bus.mem_writedata, 32'd0);
        #4 reset_n = 1'b1;
        #1 chk("clken_before_edge", {31'd0, bus.mem_clken}, 32'd0);

        // Two full words
        set_bytes(64'h8877665544332211);
        run_load(16'h0010, 0, 8, 1'b1, 1'b0, -1, 1'b0);
        chk("lit_w0_data", wlog[0].d, 32'h44332211);
        chk("lit_w0_addr", {18'd0, wlog[0].a}, 32'h10);
        chk("lit_w1_data", wlog[1].d, 32'h88776655);
        chk("lit_w1_addr", {18'd0, wlog[1].a}, 32'h11);
        chk("lit_w1_be", {28'd0, wlog[1].be}, 32'hF);

        // Partial final word
        set_bytes(64'h0000000000CCBBAA);
        base_log = wlog.size();
        run_load(16'h0005, 0, 3, 1'b1, 1'b0, -1, 1'b0);
        chk("lit_part_data", wlog[base_log].d, 32'h00CCBBAA);
        chk("lit_part_be", {28'd0, wlog[base_log].be}, 32'h7);

        // Overflow at limit=1; start asserted in the DONE cycle must be ignored
        set_bytes(64'h0000060504030201);
        base_log = wlog.size();
        run_load(0, 1, 6, 1'b1, 1'b0, -1, 1'b1);
        chk("lit_ovf_data", wlog[base_log].d, 32'h04030201);
        chk("lit_ovf_accepted", 32'(exp_acc), 32'd4);
        chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);

        // Address wrap from the top word
        set_bytes(64'h1817161514131211);
        base_log = wlog.size();
        run_load(MEM_DEPTH - 1, 0, 8, 1'b1, 1'b0, -1, 1'b0);
        chk("lit_wrap_a0", {18'd0, wlog[base_log].a}, 32'h27FF);
        chk("lit_wrap_a1", {18'd0, wlog[base_log+1].a}, 32'h0000);
        chk("wrap_ww", {17'd0, bus.words_written}, 32'd2);

        // Bubbles on in_valid plus a start pulse mid-load
        set_bytes(64'h8877665544332211);
        base_log = wlog.size();
        run_load(16'h0100, 0, 8, 1'b1, 1'b1, 2, 1'b0);
        chk("lit_bub_w0", wlog[base_log].d, 32'h44332211);
        chk("lit_bub_w1", wlog[base_log+1].d, 32'h88776655);
        chk("lit_bub_a1", {18'd0, wlog[base_log+1].a}, 32'h101);

        // Out-of-range base falls back to address 0
        set_bytes(64'h00000000DDCCBBAA);
        base_log = wlog.size();
        run_load(16'h3000, 0, 4, 1'b1, 1'b0, -1, 1'b0);
        chk("lit_badbase_a", {18'd0, wlog[base_log].a}, 32'h0);
        chk("lit_badbase_d", wlog[base_log].d, 32'hDDCCBBAA);

        // Reset after 2 of 4 bytes: nothing written, outputs back to reset values
        base_log = wlog.size();
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 14'h0200; bus.word_limit = '0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        @(negedge clk);
        bus.in_data = 8'hA5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("midrst_outputs", {bus.in_ready, bus.mem_chipselect, bus.mem_write, bus.busy,
                                  bus.done, bus.overflow, bus.mem_clken, bus.mem_byteenable}, 32'd0);
        chk("midrst_ww", {17'd0, bus.words_written}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        #1 chk("midrst_clken", {31'd0, bus.mem_clken}, 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_no_write", 32'(wlog.size()), 32'(base_log));
        chk("midrst_idle", {31'd0, bus.busy}, 32'd0);

        // Load after reset still works
        set_bytes(64'h0000000000000077);
        run_load(16'h0020, 0, 1, 1'b1, 1'b0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
